boot_memory_unit: RTL and testbench
===================================

# boot_memory_unit

Program memory stage directly downstream of the bootloader in the 8-bit CPU: a 4-bit memory address register (MAR) plus 16×8 RAM with two write ports. In bootload mode it consumes the bootloader's `data`/`bootload_address`/`bootload_ram` strobes. In run mode it serves the CPU bus control signals (MI/RI/RO). A post-reset clear sweep zeroes the RAM before either port is accepted.

## Interface
- `ADDR_W`, 4: MAR/address width; depth = 2^ADDR_W.
- `DATA_W`, 8: word width.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable_bootload`  in  1  1 = bootloader owns memory; 0 = CPU owns memory.
- `boot_data`  in  DATA_W  bootloader data byte (bootloader `data`).
- `bootload_address`  in  1  load MAR from `boot_data[ADDR_W-1:0]`.
- `bootload_ram`  in  1  write `boot_data` to RAM[MAR].
- `bus_in`  in  DATA_W  CPU bus value.
- `mar_load`  in  1  CPU MI: load MAR from `bus_in[ADDR_W-1:0]`.
- `ram_load`  in  1  CPU RI: write `bus_in` to RAM[MAR].
- `ram_out`  in  1  CPU RO: request RAM onto bus.
- `ram_data`  out  DATA_W  RAM[MAR], asynchronous read.
- `bus_drive`  out  1  bus output enable = `ram_out & ~enable_bootload & ready`.
- `mar_value`  out  ADDR_W  current MAR.
- `ready`  out  1  clear sweep done; ports accepted.

## Operation
- FSM states: CLEAR, RUN. `rst` forces CLEAR asynchronously, `clear_ptr`=0, MAR=0.
- CLEAR:
  - Each cycle writes 0 to RAM[`clear_ptr`], then increments the pointer.
  - After writing address 2^ADDR_W−1, moves to RUN. The sweep takes exactly 16 cycles.
  - All port strobes are ignored.
- RUN, `enable_bootload`=1:
  - `bootload_address` loads MAR; `bootload_ram` writes RAM[MAR].
  - CPU `mar_load`/`ram_load` are ignored.
- RUN, `enable_bootload`=0:
  - `mar_load` loads MAR; `ram_load` writes RAM[MAR].
  - Bootloader strobes are ignored.
- Simultaneous address-load and write in one cycle: the write uses the pre-edge MAR; MAR updates on the same edge.
- Only the low ADDR_W bits of the data source load MAR; upper bits are discarded.
- `enable_bootload` toggling mid-stream: the port selection is evaluated per cycle. No state is lost and MAR is retained.
- `ram_data` is forced to 0 while `ready`=0.
- RAM contents are not reset by `rst` directly; the sweep clears them.

## Timing
- Reset values: `mar_value`=0, `ready`=0, `bus_drive`=0, `ram_data`=0, checksum outputs 0.
- `ready` rises on the 16th rising edge after `rst` deasserts.
- MAR load: visible on `mar_value` after 1 edge.
- RAM write: visible on `ram_data` after 1 edge when MAR points at the written address.
- Read latency: 0 cycles, combinational from MAR.
- `rst` asserted mid-sweep or mid-bootload: immediate return to CLEAR and the sweep restarts from 0. Partial bootload contents are discarded.

## Configuration
- Macro: `BOOT_CHECKSUM_EN`.
- Defined:
  - Adds outputs `boot_checksum` (DATA_W) and `boot_count` (ADDR_W+1).
  - Each accepted bootloader write adds `boot_data` to the checksum (mod 2^DATA_W) and increments the count, saturating at 2^ADDR_W.
  - Both are cleared by `rst` and by the rising edge of `enable_bootload`.
  - CPU writes do not affect either.
- Undefined: the ports and logic are absent. Memory behaviour is identical.

## Test plan
- Reset then release: `ready`=0 for 15 edges and 1 on the 16th. Reading all 16 addresses via `mar_load` returns 0x00.
- Bootload with `enable_bootload`=1: address 0x3 then `boot_data`=0xA5 with `bootload_ram` → `mar_value`=3, `ram_data`=0xA5. The CPU reads 0xA5 at addr 3 with `bus_drive`=1.
- Port isolation: `enable_bootload`=1 with `ram_load`, `bus_in`=0xFF → RAM unchanged. `enable_bootload`=0 with `bootload_ram` → unchanged.
- Same-cycle `bootload_address` (data 0x07) and `bootload_ram` with MAR=2 → RAM[2]=0x07, MAR=7.
- `rst` pulse mid-bootload after writing addr 0–5 → `ready` drops, and after 16 cycles addr 0–5 read 0x00.
- `BOOT_CHECKSUM_EN`: write 0x80, 0x90, 0x01 → `boot_checksum`=0x11, `boot_count`=3. 20 writes → `boot_count`=16.

Source files
------------

// File: rtl/boot_memory_unit.sv
// boot_memory_unit: 4-bit MAR plus 16x8 program RAM that sits behind the bootloader.
// After reset a clear sweep zeroes every RAM word, then the memory is served either
// to the bootloader (enable_bootload=1) or to the CPU bus control signals (MI/RI/RO).
// Optional feature macro: BOOT_CHECKSUM_EN adds a running checksum and write count
// of accepted bootloader writes.
module boot_memory_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_bootload,
  input  logic [DATA_W-1:0] boot_data,
  input  logic              bootload_address,
  input  logic              bootload_ram,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_load,
  input  logic              ram_load,
  input  logic              ram_out,
  output logic [DATA_W-1:0] ram_data,
  output logic              bus_drive,
  output logic [ADDR_W-1:0] mar_value,
`ifdef BOOT_CHECKSUM_EN
  output logic [DATA_W-1:0] boot_checksum,
  output logic [ADDR_W:0]   boot_count,
`endif
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clear_ptr;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              mar_ld;
  logic [ADDR_W-1:0] mar_next;

  // Select which port owns the write and MAR-load paths this cycle; the sweep overrides both ports.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = mar;
    wr_data  = '0;
    mar_ld   = 1'b0;
    mar_next = mar;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clear_ptr;
      wr_data = '0;
    end else if (enable_bootload) begin
      wr_en    = bootload_ram;
      wr_data  = boot_data;
      mar_ld   = bootload_address;
      mar_next = boot_data[ADDR_W-1:0];
    end else begin
      wr_en    = ram_load;
      wr_data  = bus_in;
      mar_ld   = mar_load;
      mar_next = bus_in[ADDR_W-1:0];
    end
  end

  // Sequencer: sweep pointer, MAR and the registered ready flag; reset restarts the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clear_ptr <= '0;
      mar       <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clear_ptr <= clear_ptr + 1'b1;
          if (clear_ptr == {ADDR_W{1'b1}}) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (mar_ld) mar <= mar_next;
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // RAM array has no reset; the write uses the pre-edge MAR so a same-cycle address load cannot redirect it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign mar_value = mar;
  assign ram_data  = ready ? mem[mar] : '0;
  assign bus_drive = ram_out & ~enable_bootload & ready;

`ifdef BOOT_CHECKSUM_EN
  localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(DEPTH);

  logic enable_q;
  logic boot_wr;
  logic boot_rise;

  assign boot_wr   = (state == RUN) && enable_bootload && bootload_ram;
  assign boot_rise = enable_bootload && !enable_q;

  // Checksum and count of accepted bootloader writes, restarted on each new bootload session.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q      <= 1'b0;
      boot_checksum <= '0;
      boot_count    <= '0;
    end else begin
      enable_q <= enable_bootload;
      if (boot_rise) begin
        boot_checksum <= boot_wr ? boot_data : '0;
        boot_count    <= boot_wr ? (ADDR_W + 1)'(1) : '0;
      end else if (boot_wr) begin
        boot_checksum <= boot_checksum + boot_data;
        if (boot_count != COUNT_MAX) boot_count <= boot_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_boot_memory_unit.sv
// tb_boot_memory_unit: directed scoreboard bench for boot_memory_unit.
// Expected values are queued when a step is driven and popped after the edge.
// Build with BOOT_CHECKSUM_EN defined to also exercise the checksum outputs.
module tb_boot_memory_unit;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  localparam int SEL_MAR   = 0;
  localparam int SEL_READY = 1;
  localparam int SEL_DRIVE = 2;
  localparam int SEL_DATA  = 3;
  localparam int SEL_CSUM  = 4;
  localparam int SEL_COUNT = 5;

  logic              clk;
  logic              rst;
  logic              enable_bootload;
  logic [DATA_W-1:0] boot_data;
  logic              bootload_address;
  logic              bootload_ram;
  logic [DATA_W-1:0] bus_in;
  logic              mar_load;
  logic              ram_load;
  logic              ram_out;
  logic [DATA_W-1:0] ram_data;
  logic              bus_drive;
  logic [ADDR_W-1:0] mar_value;
  logic              ready;
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] boot_checksum;
  logic [ADDR_W:0]   boot_count;
`endif

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] value;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  boot_memory_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_bootload  (enable_bootload),
    .boot_data        (boot_data),
    .bootload_address (bootload_address),
    .bootload_ram     (bootload_ram),
    .bus_in           (bus_in),
    .mar_load         (mar_load),
    .ram_load         (ram_load),
    .ram_out          (ram_out),
    .ram_data         (ram_data),
    .bus_drive        (bus_drive),
    .mar_value        (mar_value),
`ifdef BOOT_CHECKSUM_EN
    .boot_checksum    (boot_checksum),
    .boot_count       (boot_count),
`endif
    .ready            (ready)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Map a scoreboard selector onto the matching DUT output.
  function automatic logic [15:0] observed(int sel);
    case (sel)
      SEL_MAR:   return {12'b0, mar_value};
      SEL_READY: return {15'b0, ready};
      SEL_DRIVE: return {15'b0, bus_drive};
      SEL_DATA:  return {8'b0, ram_data};
`ifdef BOOT_CHECKSUM_EN
      SEL_CSUM:  return {8'b0, boot_checksum};
      SEL_COUNT: return {11'b0, boot_count};
`endif
      default:   return 16'hdead;
    endcase
  endfunction

  // Queue one expected value for the next check.
  task automatic expectVal(input string tag, input int sel, input logic [15:0] value);
    exp_t e;
    e.tag   = tag;
    e.sel   = sel;
    e.value = value;
    sb.push_back(e);
  endtask

  // Drive one cycle of stimulus, wait past the edge, then drop the one-shot strobes.
  task automatic applyStimulus(input logic en, input logic baddr, input logic bram,
                               input logic [7:0] bdata, input logic mld, input logic rld,
                               input logic rout, input logic [7:0] bus);
    enable_bootload  = en;
    bootload_address = baddr;
    bootload_ram     = bram;
    boot_data        = bdata;
    mar_load         = mld;
    ram_load         = rld;
    ram_out          = rout;
    bus_in           = bus;
    @(posedge clk);
    #1;
    bootload_address = 1'b0;
    bootload_ram     = 1'b0;
    mar_load         = 1'b0;
    ram_load         = 1'b0;
  endtask

  // Pop every queued expectation and compare it with the DUT.
  task automatic checkOutput();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observed(e.sel);
      vectors++;
      assert (obs === e.value) else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.value);
      end
    end
  endtask

  // Idle step with CPU owning the bus and no strobes.
  task automatic idleStep(input logic en);
    applyStimulus(en, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // CPU read of one address via MI; checks MAR and the read data.
  task automatic cpuRead(input logic [3:0] addr, input logic [7:0] data, input string tag);
    expectVal({tag, "_mar"}, SEL_MAR, {12'b0, addr});
    expectVal({tag, "_data"}, SEL_DATA, {8'b0, data});
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, {4'h0, addr});
    checkOutput();
  endtask

  // Watch the clear sweep: ready low for 15 edges, high on the 16th.
  task automatic checkSweep(input string tag);
    for (int i = 1; i <= 16; i++) begin
      expectVal($sformatf("%s_ready_edge%0d", tag, i), SEL_READY, (i == 16) ? 16'h1 : 16'h0);
      idleStep(1'b0);
      checkOutput();
    end
  endtask

  // Directed sequence.
  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    enable_bootload  = 1'b0;
    boot_data        = '0;
    bootload_address = 1'b0;
    bootload_ram     = 1'b0;
    bus_in           = '0;
    mar_load         = 1'b0;
    ram_load         = 1'b0;
    ram_out          = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    expectVal("rst_mar", SEL_MAR, 16'h0);
    expectVal("rst_ready", SEL_READY, 16'h0);
    expectVal("rst_bus_drive", SEL_DRIVE, 16'h0);
    expectVal("rst_ram_data", SEL_DATA, 16'h0);
`ifdef BOOT_CHECKSUM_EN
    expectVal("rst_checksum", SEL_CSUM, 16'h0);
    expectVal("rst_count", SEL_COUNT, 16'h0);
`endif
    checkOutput();
    rst     = 1'b0;
    ram_out = 1'b0;

    $display("[TB] clear sweep after reset");
    checkSweep("sweep1");

    $display("[TB] readback of cleared RAM");
    for (int a = 0; a < 16; a++) cpuRead(4'(a), 8'h00, $sformatf("clr%0d", a));

    $display("[TB] bootload write");
    expectVal("boot_mar", SEL_MAR, 16'h3);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput();
    expectVal("boot_wr_data", SEL_DATA, 16'h00a5);
    expectVal("boot_no_drive", SEL_DRIVE, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'ha5, 1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput();
    enable_bootload = 1'b0;
    #1;
    expectVal("cpu_rd_drive", SEL_DRIVE, 16'h1);
    expectVal("cpu_rd_data", SEL_DATA, 16'h00a5);
    checkOutput();
    ram_out = 1'b0;

    $display("[TB] port isolation");
    expectVal("iso_cpu_mar", SEL_MAR, 16'h3);
    expectVal("iso_cpu_data", SEL_DATA, 16'h00a5);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hff);
    checkOutput();
    expectVal("iso_boot_mar", SEL_MAR, 16'h3);
    expectVal("iso_boot_data", SEL_DATA, 16'h00a5);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5a, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput();

    $display("[TB] MAR upper bits discarded, CPU write");
    expectVal("trunc_mar", SEL_MAR, 16'h2);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hf2);
    checkOutput();
    expectVal("cpu_wr_data", SEL_DATA, 16'h003c);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3c);
    checkOutput();

    $display("[TB] same-cycle address load and write");
    expectVal("same_mar", SEL_MAR, 16'h7);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput();
    cpuRead(4'h7, 8'h00, "same_new_addr");
    cpuRead(4'h2, 8'h07, "same_old_addr");
    cpuRead(4'h3, 8'ha5, "keep_addr3");

    $display("[TB] reset during bootload");
    for (int a = 0; a < 6; a++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'(a), 1'b0, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'(8'h10 + a), 1'b0, 1'b0, 1'b0, 8'h00);
    end
    cpuRead(4'h5, 8'h15, "pre_rst_addr5");
    #2;
    rst = 1'b1;
    #1;
    expectVal("mid_rst_ready", SEL_READY, 16'h0);
    expectVal("mid_rst_data", SEL_DATA, 16'h0);
    expectVal("mid_rst_mar", SEL_MAR, 16'h0);
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkSweep("sweep2");
    for (int a = 0; a < 6; a++) cpuRead(4'(a), 8'h00, $sformatf("post_rst%0d", a));

`ifdef BOOT_CHECKSUM_EN
    $display("[TB] bootload checksum");
    expectVal("cs_rise_sum", SEL_CSUM, 16'h0);
    expectVal("cs_rise_count", SEL_COUNT, 16'h0);
    idleStep(1'b1);
    checkOutput();
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h90, 1'b0, 1'b0, 1'b0, 8'h00);
    expectVal("cs_sum3", SEL_CSUM, 16'h0011);
    expectVal("cs_count3", SEL_COUNT, 16'h3);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput();
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00);
    expectVal("cs_count_sat", SEL_COUNT, 16'h10);
    expectVal("cs_sum20", SEL_CSUM, 16'h0022);
    checkOutput();
    expectVal("cs_cpu_count", SEL_COUNT, 16'h10);
    expectVal("cs_cpu_sum", SEL_CSUM, 16'h0022);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h44);
    checkOutput();
    expectVal("cs_reclear_count", SEL_COUNT, 16'h0);
    expectVal("cs_reclear_sum", SEL_CSUM, 16'h0);
    idleStep(1'b1);
    checkOutput();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
